force_seq_arbiter: RTL
======================

# force_seq_arbiter

Arbitrates force/release requests from up to NREQ software or bench requesters onto a single forceable clocked register. It owns the register and its force overlay, and sequences each granted request through force, hold and release, so the register is never forced by two requesters at once. Used in VPI/DPI force regression designs in place of an ad-hoc forceable register.

## Interface
- `WIDTH`, 1: width of the target register and of the force values.
- `NREQ`, 4: number of requesters, 2..16.
- `HOLD_W`, 8: width of the per-request hold count.
- `clk`  in  1  clock; everything samples on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `d_in`  in  WIDTH  normal register input, sampled every cycle.
- `req_valid`  in  NREQ  per-requester force request; held until `req_ack`.
- `req_value`  in  NREQ*WIDTH  packed force values; requester i uses slice [i*WIDTH +: WIDTH].
- `req_hold`  in  NREQ*HOLD_W  packed hold counts; the force lasts hold+1 cycles.
- `release_all`  in  1  early-release strobe.
- `req_ack`  out  NREQ  one-hot, one-cycle pulse when a request is accepted.
- `q`  out  WIDTH  visible register value (with the force overlay applied).
- `forced`  out  1  high while the overlay is active.
- `owner`  out  $clog2(NREQ)  index of the current or last granted requester.
- `done`  out  1  one-cycle pulse in the RELEASE state.

## Operation
- Internal register `r` loads `d_in` on every edge, including while forced. A force never blocks sampling.
- Output: `q = forced ? fval : r`. Release therefore behaves like a net release: `q` shows the latest `r` immediately.
- FSM states: IDLE, HOLD, RELEASE.
- IDLE:
  - If any `req_valid` is set and `release_all` is low, grant the round-robin winner.
  - The winner is the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - On grant: pulse `req_ack[w]`; latch `fval = req_value[w]`, `cnt = req_hold[w]`, `owner = w`; set `rr_ptr = (w+1) mod NREQ`; go to HOLD.
- HOLD:
  - `forced = 1`.
  - If `release_all` is high, go to RELEASE.
  - Else if `cnt == 0`, go to RELEASE.
  - Else decrement `cnt` and stay.
- RELEASE:
  - `forced = 0`, `done = 1`; go to IDLE.
  - No grant is made in this state, so there is at least one unforced cycle between consecutive forces.
- Rules:
  - `req_valid` bits not granted are ignored; they are not queued.
  - A requester dropping `req_valid` before its ack is legal and simply withdraws the request.
  - `release_all` in IDLE or RELEASE has no effect. In IDLE it also suppresses the grant for that cycle.
  - `req_hold` is unsigned, so the maximum force length is 2^HOLD_W cycles.
- Reset (async assert, synchronous deassert by the environment) forces these values: state IDLE, `r = 0`, `fval = 0`, `cnt = 0`, `rr_ptr = 0`, `owner = 0`, `forced = 0`, `done = 0`, `req_ack = 0`, `q = 0`.
- Reset mid-force drops the overlay immediately and asynchronously.

## Timing
- Acceptance: if a request is seen at edge E, `req_ack` and the grant are registered at E.
- `forced` rises at E and stays high for exactly hold+1 cycles, assuming no `release_all`.
- The first cycle after the last forced cycle is RELEASE, with `done` high and `forced` low.
- The earliest next grant is at the edge that ends RELEASE.
- `release_all` sampled high at edge F while in HOLD: `forced` falls at F, regardless of `cnt`.
- `q` is combinational from `forced`, `fval` and `r`; there is no extra latency.
- `r` follows `d_in` with 1 cycle of latency.

## Configuration
- `FORCE_SEQ_STATS_EN` defined: adds output `force_count` (16 bits).
  - Reset to 0.
  - Increments by one on each RELEASE cycle, saturating at 0xFFFF.
  - Adds output `early_release` (1 bit), which is sticky high once a HOLD has been ended by `release_all`, and cleared only by reset.
- Not defined: both ports and their logic are absent. The core behaviour is identical either way.

## Test plan
- Reset, WIDTH=1, `d_in` toggling every cycle, no requests → `q` tracks `d_in` one cycle late; `forced = 0`, `req_ack = 0`, `done = 0`.
- Requester 2 with value 1 and hold 3, `d_in = 0` → one `req_ack = 4'b0100` pulse, `owner = 2`, `q = 1` for exactly 4 cycles, then `done` for 1 cycle with `q = 0`.
- Requesters 0 and 3 asserted continuously, hold 0 → grants alternate 0,3,0,3; each force lasts 1 cycle, followed by 1 RELEASE cycle.
- Hold 200, then `release_all` pulsed on the 5th forced cycle → `forced` low at the next edge, `done` pulse; with STATS, `early_release = 1` and `force_count` +1.
- `rst_n` driven low during HOLD → `q`, `forced` and `owner` drop to 0 without a clock edge; after reset, the pending request is re-granted from requester 0.
- `release_all` high in IDLE together with `req_valid[1]` → no ack that cycle; ack on the following cycle once `release_all` is low.

Source files
------------

// File: rtl/force_seq_arbiter_if.sv
// Handshake and data bundle for force_seq_arbiter: requester side (master) and
// the arbiter that owns the forceable register (slave).
interface force_seq_arbiter_if #(
  parameter int WIDTH  = 1,
  parameter int NREQ   = 4,
  parameter int HOLD_W = 8
);
  localparam int OWN_W = $clog2(NREQ);

  logic [WIDTH-1:0]       d_in;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_value;
  logic [NREQ*HOLD_W-1:0] req_hold;
  logic                   release_all;
  logic [NREQ-1:0]        req_ack;
  logic [WIDTH-1:0]       q;
  logic                   forced;
  logic [OWN_W-1:0]       owner;
  logic                   done;

  modport master (
    output d_in, req_valid, req_value, req_hold, release_all,
    input  req_ack, q, forced, owner, done
  );

  modport slave (
    input  d_in, req_valid, req_value, req_hold, release_all,
    output req_ack, q, forced, owner, done
  );
endinterface

// File: rtl/force_seq_arbiter.sv
// Round-robin arbiter sequencing force/hold/release of one register overlay.
// Optional statistics outputs are built when FORCE_SEQ_STATS_EN is defined.
module force_seq_arbiter #(
  parameter int WIDTH  = 1,
  parameter int NREQ   = 4,
  parameter int HOLD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  force_seq_arbiter_if.slave  bus
`ifdef FORCE_SEQ_STATS_EN
  ,
  output logic [15:0]         force_count,
  output logic                early_release
`endif
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  fval_q, fval_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [WIDTH-1:0]  value_arr [NREQ];
  logic [HOLD_W-1:0] hold_arr  [NREQ];
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic              forced_w;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign value_arr[g] = bus.req_value[g*WIDTH +: WIDTH];
    assign hold_arr[g]  = bus.req_hold[g*HOLD_W +: HOLD_W];
  end

  // Scan from rr_ptr upward with wrap; the first set bit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == PTR_W'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    fval_d   = fval_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    ack_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found && !bus.release_all) begin
          ack_d    = NREQ'(1) << grant_idx;
          fval_d   = value_arr[grant_idx];
          cnt_d    = hold_arr[grant_idx];
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.release_all || cnt_q == '0) begin
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      fval_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      ack_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      r_q      <= bus.d_in;
      fval_q   <= fval_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
    end
  end

  // The overlay is purely combinational, so dropping it shows the latest r at once.
  assign forced_w    = (state_q == S_HOLD);
  assign bus.forced  = forced_w;
  assign bus.done    = (state_q == S_RELEASE);
  assign bus.q       = forced_w ? fval_q : r_q;
  assign bus.owner   = owner_q;
  assign bus.req_ack = ack_q;

`ifdef FORCE_SEQ_STATS_EN
  logic [15:0] force_count_q;
  logic        early_release_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_count_q   <= '0;
      early_release_q <= 1'b0;
    end else begin
      if (state_q == S_RELEASE && force_count_q != 16'hFFFF) begin
        force_count_q <= force_count_q + 16'd1;
      end
      if (state_q == S_HOLD && bus.release_all) begin
        early_release_q <= 1'b1;
      end
    end
  end

  assign force_count   = force_count_q;
  assign early_release = early_release_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
